// File: rtl/hdc_ngram_encoder_if.sv
// Handshake bundle for the n-gram encoder: symbol stream in, item-memory read, query hypervector out.
interface hdc_ngram_encoder_if #(
  parameter int D     = 512,
  parameter int SYM_W = 8,
  parameter int CNT_W = 8
);
  logic             sym_valid;
  logic             sym_ready;
  logic [SYM_W-1:0] sym_data;
  logic             sym_last;
  logic             im_rd;
  logic [SYM_W-1:0] im_addr;
  logic [D-1:0]     im_data;
  logic             hv_valid;
  logic             hv_ready;
  logic [D-1:0]     hv_data;
  logic [CNT_W-1:0] hv_ngrams;

  modport slave (
    input  sym_valid, sym_data, sym_last, im_data, hv_ready,
    output sym_ready, im_rd, im_addr, hv_valid, hv_data, hv_ngrams
  );

  modport master (
    output sym_valid, sym_data, sym_last, im_data, hv_ready,
    input  sym_ready, im_rd, im_addr, hv_valid, hv_data, hv_ngrams
  );
endinterface

// File: rtl/hdc_ngram_encoder.sv
// Sliding N-gram hypervector encoder: permute-and-XOR binding, per-bit saturating
// bundling counters, majority threshold emitted once per text.
module hdc_ngram_encoder #(
  parameter int D     = 512,
  parameter int N     = 3,
  parameter int SYM_W = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  hdc_ngram_encoder_if.slave bus
);
  typedef enum logic [2:0] {S_IN, S_REQ, S_CAP, S_THR, S_OUT} state_t;

  localparam int FW = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t                      state_q, state_d;
  logic [SYM_W-1:0]            addr_q;
  logic                        last_q;
  logic [N-1:0][D-1:0]         win_q, win_d;
  logic [FW-1:0]               fill_q;
  logic [D-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]            k_q, ngr_q;
  logic [D-1:0]                hv_q, hv_d, gram;
  logic                        full_d, bump, clr, acc_sym;

  function automatic logic [D-1:0] rotl(input logic [D-1:0] v, input int s);
    logic [2*D-1:0] w;
    w = {v, v} << s;
    return w[2*D-1:D];
  endfunction

  assign acc_sym = (state_q == S_IN) && bus.sym_valid;
  assign clr     = (state_q == S_OUT) && bus.hv_ready;
  assign bump    = (state_q == S_CAP) && full_d;

  // Post-shift window and the bound n-gram; oldest symbol gets the largest rotate.
  always_comb begin
    win_d[0] = bus.im_data;
    for (int i = 1; i < N; i++) win_d[i] = win_q[i-1];
    gram = '0;
    for (int i = 0; i < N; i++) gram = gram ^ rotl(win_d[i], i);
    full_d = (int'(fill_q) + 1) >= N;
  end

  for (genvar j = 0; j < D; j++) begin : g_bit
    assign cnt_d[j] = clr ? '0 :
                      (bump && gram[j] && cnt_q[j] != CMAX) ? cnt_q[j] + CNT_W'(1) : cnt_q[j];
    // Strict majority; a tie (2*cnt == K) yields 0.
    assign hv_d[j]  = {cnt_q[j], 1'b0} > {1'b0, k_q};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IN:    if (bus.sym_valid) state_d = S_REQ;
      S_REQ:   state_d = S_CAP;
      S_CAP:   state_d = last_q ? S_THR : S_IN;
      S_THR:   state_d = S_OUT;
      S_OUT:   if (bus.hv_ready) state_d = S_IN;
      default: state_d = S_IN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      last_q <= 1'b0;
      win_q  <= '0;
      fill_q <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
      hv_q   <= '0;
      ngr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (acc_sym) begin
        addr_q <= bus.sym_data;
        last_q <= bus.sym_last;
      end
      if (state_q == S_CAP) begin
        win_q <= win_d;
        if (fill_q != FW'(N)) fill_q <= fill_q + FW'(1);
        if (full_d && k_q != CMAX) k_q <= k_q + CNT_W'(1);
      end
      if (state_q == S_THR) begin
        hv_q  <= hv_d;
        ngr_q <= k_q;
      end
      if (clr) begin
        win_q  <= '0;
        fill_q <= '0;
        k_q    <= '0;
      end
    end
  end

  assign bus.sym_ready = (state_q == S_IN);
  assign bus.im_rd     = (state_q == S_REQ);
  assign bus.im_addr   = addr_q;
  assign bus.hv_valid  = (state_q == S_OUT);
  assign bus.hv_data   = hv_q;
  assign bus.hv_ngrams = ngr_q;
endmodule

// File: tb/tb_hdc_ngram_encoder.sv
// Directed + one random text through the encoder, with an item-memory model and an output scoreboard.
module tb_hdc_ngram_encoder;
  localparam int D = 8, N = 3, SW = 8, CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hdc_ngram_encoder_if #(.D(D), .SYM_W(SW), .CNT_W(CW)) bus();
  hdc_ngram_encoder #(.D(D), .N(N), .SYM_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [7:0] rom [256];
  always @(posedge clk) if (bus.im_rd) bus.im_data <= rom[bus.im_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, n_out = 0, last_acc = 0, first_acc = 0;
  logic [15:0] sb[$];
  logic [7:0]  q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] v, input int i);
    logic [15:0] w;
    w = {v, v} << i;
    return w[15:8];
  endfunction

  function automatic logic [15:0] model(input logic [7:0] s[$]);
    int cnt[8];
    int k;
    logic [7:0] g, hv;
    k = 0;
    for (int j = 0; j < 8; j++) cnt[j] = 0;
    for (int p = N - 1; p < s.size(); p++) begin
      g = '0;
      for (int i = 0; i < N; i++) g = g ^ rl(rom[s[p-i]], i);
      if (k < 255) k++;
      for (int j = 0; j < 8; j++) if (g[j] && cnt[j] < 255) cnt[j]++;
    end
    for (int j = 0; j < 8; j++) hv[j] = (2 * cnt[j] > k);
    return {hv, 8'(k)};
  endfunction

  // Scoreboard: pop on every accepted query hypervector.
  always @(negedge clk) begin
    if (!reset && bus.hv_valid && bus.hv_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected: observed hv %0h with empty scoreboard", bus.hv_data);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        chk("sb_hv_data", 32'(bus.hv_data), 32'(e[15:8]));
        chk("sb_hv_ngrams", 32'(bus.hv_ngrams), 32'(e[7:0]));
      end
    end
  end

  task automatic send_sym(input logic [7:0] s, input logic l);
    bus.sym_valid = 1'b1;
    bus.sym_data  = s;
    bus.sym_last  = l;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.sym_ready) break;
    end
    chk("sym_accept", 32'(bus.sym_ready), 32'd1);
    last_acc = cyc;
    @(posedge clk); #1;
    bus.sym_valid = 1'b0;
    bus.sym_last  = 1'b0;
  endtask

  task automatic send_text(input logic [7:0] s[$], input logic [15:0] exp);
    sb.push_back(exp);
    foreach (s[i]) begin
      send_sym(s[i], i == s.size() - 1);
      if (i == 0) first_acc = last_acc;
    end
  endtask

  task automatic wait_hv(input string tag);
    int k;
    k = 0;
    while (!bus.hv_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, 32'(bus.hv_valid), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(last_acc + 4));
    @(posedge clk); #1;
    if (bus.hv_ready) begin
      @(negedge clk);
      chk({tag, "_deassert"}, 32'(bus.hv_valid), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] e;
    int rel;
    bus.sym_valid = 1'b0;
    bus.sym_data  = '0;
    bus.sym_last  = 1'b0;
    bus.hv_ready  = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[1] = 8'h01; rom[2] = 8'h02; rom[3] = 8'h04; rom[4] = 8'h08; rom[5] = 8'h81;

    #1 reset = 1'b1;
    #3;
    chk("rst_sym_ready", 32'(bus.sym_ready), 32'd1);
    chk("rst_im_rd", 32'(bus.im_rd), 32'd0);
    chk("rst_im_addr", 32'(bus.im_addr), 32'd0);
    chk("rst_hv_valid", 32'(bus.hv_valid), 32'd0);
    chk("rst_hv_data", 32'(bus.hv_data), 32'd0);
    chk("rst_hv_ngrams", 32'(bus.hv_ngrams), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    q = {8'd1, 8'd2, 8'd3};        send_text(q, 16'h0401); wait_hv("abc");
    q = {8'd5, 8'd5, 8'd5, 8'd5};  send_text(q, 16'h8402); wait_hv("aaaa");
    q = {8'd1, 8'd2, 8'd3, 8'd4};  send_text(q, 16'h0002); wait_hv("tie");
    q = {8'd1, 8'd2};              send_text(q, 16'h0000); wait_hv("short");
    q = {8'd1, 8'd2, 8'd3};        send_text(q, 16'h0401); wait_hv("after_short");
    q = {8'd3};                    send_text(q, 16'h0000); wait_hv("single");

    // Output back-pressure with a symbol waiting upstream.
    bus.hv_ready = 1'b0;
    q = {8'd1, 8'd2, 8'd3};        send_text(q, 16'h0401); wait_hv("bp");
    bus.sym_valid = 1'b1;
    bus.sym_data  = 8'd1;
    bus.sym_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_sym_ready", 32'(bus.sym_ready), 32'd0);
      chk("bp_hv_valid", 32'(bus.hv_valid), 32'd1);
      chk("bp_hv_data", 32'(bus.hv_data), 32'h04);
    end
    @(posedge clk); #1;
    rel = cyc;
    bus.hv_ready = 1'b1;
    q = {8'd1, 8'd2, 8'd3};        send_text(q, 16'h0401);
    chk("bp_restart_cycle", 32'(first_acc), 32'(rel + 1));
    wait_hv("bp_next");

    // Reset in the middle of a text.
    send_sym(8'd1, 1'b0);
    send_sym(8'd2, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_sym_ready", 32'(bus.sym_ready), 32'd1);
    chk("midrst_im_rd", 32'(bus.im_rd), 32'd0);
    chk("midrst_im_addr", 32'(bus.im_addr), 32'd0);
    chk("midrst_hv_valid", 32'(bus.hv_valid), 32'd0);
    chk("midrst_hv_data", 32'(bus.hv_data), 32'd0);
    chk("midrst_hv_ngrams", 32'(bus.hv_ngrams), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    q = {8'd1, 8'd2, 8'd3};        send_text(q, 16'h0401); wait_hv("post_rst");

    // Random item vectors and symbols against the reference model.
    for (int i = 10; i < 18; i++) rom[i] = 8'($urandom);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom_range(10, 17)));
    e = model(q);
    send_text(q, e);               wait_hv("random");

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("out_count", 32'(n_out), 32'd10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hdc_ngram_encoder.md
Name: hdc_ngram_encoder

Overview:
- Sits directly downstream of tokenizer_module and upstream of the associative-memory classifier inside main.
- Consumes the tokenizer's symbol stream, one symbol ID per handshake, with a last flag on the final symbol of a text.
- For each symbol, looks up the symbol's item hypervector in an external item memory. Binds a sliding N-gram window by permute-and-XOR, then bundles all N-grams of the text in per-bit counters.
- At end of text, emits one majority-thresholded query hypervector.

Parameters:
- D, 512, hypervector dimension in bits.
- N, 3, n-gram length (N >= 2).
- SYM_W, 8, symbol ID width.
- CNT_W, 8, width of each per-bit bundling counter and of the n-gram count; saturating.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sym_valid  in  1  symbol present on sym_data.
- sym_ready  out  1  block can accept a symbol.
- sym_data  in  SYM_W  symbol ID.
- sym_last  in  1  qualifies sym_data as the final symbol of the text.
- im_rd  out  1  item-memory read strobe.
- im_addr  out  SYM_W  item-memory address (symbol ID).
- im_data  in  D  item hypervector; valid exactly one cycle after im_rd.
- hv_valid  out  1  query hypervector valid.
- hv_ready  in  1  consumer accepts the query hypervector.
- hv_data  out  D  bundled, thresholded query hypervector.
- hv_ngrams  out  CNT_W  number of n-grams bundled (K).

Behaviour:
- Reset (async, immediate): state returns to S_IN.
  - Outputs: sym_ready=1, im_rd=0, im_addr=0, hv_valid=0, hv_data=0, hv_ngrams=0.
  - Internal: all counters, K, window fill count and window registers clear to 0.
  - Reset mid-text or mid-output discards all partial work; no hv_valid follows.
- FSM states: S_IN, S_REQ, S_CAP, S_THR, S_OUT. All outputs are registered or state-decoded.
- S_IN:
  - sym_ready=1; all other handshake outputs low.
  - On sym_valid&&sym_ready: register im_addr<=sym_data and last_q<=sym_last; go to S_REQ.
- S_REQ: im_rd=1 for exactly one cycle; go to S_CAP.
- S_CAP: im_data is sampled this cycle.
  - Window: shift W[N-1..1]<=W[N-2..0], W[0]<=im_data.
  - Fill count: fill<=min(fill+1, N).
  - N-gram condition: if fill+1 >= N (window full including the new vector), form G = XOR over i=0..N-1 of rotl(W'[i], i).
    - W' is the post-shift window; W'[0] is the newest vector.
    - rotl is a circular left rotate by i bits of the D-bit vector, so the oldest symbol is rotated by N-1.
    - For each bit j: cnt[j] += G[j]. Also K += 1.
    - cnt and K saturate at 2^CNT_W-1; no wrap.
  - Next state: S_THR if last_q, else S_IN.
- S_THR:
  - hv_data[j] <= (2*cnt[j] > K), computed in CNT_W+1 bits.
  - Tie (2*cnt[j]==K) resolves to 0.
  - hv_ngrams <= K; go to S_OUT.
- S_OUT:
  - hv_valid=1; hv_data and hv_ngrams hold stable until hv_ready.
  - On hv_valid&&hv_ready: clear cnt, K, fill and the window; go to S_IN.
  - hv_valid deasserts the cycle after acceptance. hv_data and hv_ngrams keep their values until the next S_THR.
- Throughput and latency:
  - One symbol per 3 cycles.
  - Last symbol accepted in cycle T gives hv_valid high in cycle T+4 (S_REQ T+1, S_CAP T+2, S_THR T+3, S_OUT T+4).
- Short text: if fewer than N symbols precede and include sym_last, then K=0 and the output is hv_data=0, hv_ngrams=0, still presented with a normal hv_valid handshake.
- Single-symbol text with sym_last=1 is legal and follows the short-text rule.
- Back-pressure:
  - sym_ready is low in all states except S_IN.
  - The block never drops a symbol; upstream holds sym_valid/sym_data stable while sym_ready=0.
- Simultaneous events: in S_OUT, a sym_valid present is ignored (sym_ready=0) until the cycle after hv acceptance.

Test Plan:
- D=8, N=3; ROM a=0x01, b=0x02, c=0x04; stream a,b,c(last) -> G=0x04, hv_data=0x04, hv_ngrams=1; hv_valid exactly 4 cycles after the last accept.
- D=8, N=3; ROM a=0x81; stream a,a,a,a(last) -> two n-grams of 0x84; hv_data=0x84, hv_ngrams=2.
- Tie: D=8, N=3; ROM a=01, b=02, c=04, d=08; stream a,b,c,d(last) -> n-grams 0x04 and 0x08, K=2, bits tied -> hv_data=0x00, hv_ngrams=2.
- Short text: stream a,b(last) -> hv_data=0, hv_ngrams=0, one hv_valid pulse. Then a following text a,b,c(last) -> 0x04, proving clear-on-accept.
- Back-pressure: hold hv_ready=0 for 10 cycles with sym_valid=1 -> sym_ready stays 0, hv_data stable. Release -> next text starts one cycle later, no symbol lost.
- Reset mid-text: assert reset after 2 of 3 symbols -> outputs at reset values immediately. Then a,b,c(last) -> hv_data=0x04, hv_ngrams=1 (no residue).
- Optional: CNT_W=2, stream of 6 identical symbols a=0x81 -> K saturates at 3, cnt saturates, hv_data=0x84.
